// File: rtl/fp16_result_decoder.sv
// ============================================================================
// fp16_result_decoder : binary16 FPU result to signed 5.3 BCD display digits
// Rev 1.0
// ============================================================================
`default_nettype none

module fp16_result_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result_in,
    input  logic        ready_in,
    input  logic        error_in,
    output logic        busy,
    output logic        done,
    output logic        sign_out,
    output logic [19:0] int_bcd,
    output logic [11:0] frac_bcd,
    output logic        ovf,
    output logic        err,
    output logic        zero
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_INT  = 3'd2,
        S_FRAC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0] C_INT_LAST  = 4'd15;
    localparam logic [3:0] C_FRAC_LAST = 4'd2;

    state_t      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic        err_cap_q, err_cap_d;
    logic [15:0] int_sr_q, int_sr_d;
    logic [15:0] frac_q, frac_d;
    logic [19:0] bcd_int_q, bcd_int_d;
    logic [11:0] bcd_frac_q, bcd_frac_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sign_out_q, sign_out_d;
    logic [19:0] int_bcd_q, int_bcd_d;
    logic [11:0] frac_bcd_q, frac_bcd_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic        zero_q, zero_d;

    logic [4:0]  w_exp;
    logic [9:0]  w_frac;
    logic [31:0] w_mant;
    logic [31:0] w_fixed;
    logic        w_special;
    logic [15:0] w_adj;
    logic [19:0] w_prod;

    assign w_exp     = word_q[14:10];
    assign w_frac    = word_q[9:0];
    assign w_mant    = {21'd0, (w_exp != 5'd0), w_frac};
    assign w_special = err_cap_q | (w_exp == 5'd31);
    assign w_prod    = {4'd0, frac_q} * 20'd10;

    // Q16.16 placement: value * 2^16 = mant * 2^(exp-9); subnormals use exp-9 = -8
    always_comb begin
        w_fixed = 32'd0;
        if (w_exp == 5'd0) begin
            w_fixed = w_mant >> 8;
        end else if (w_exp >= 5'd9) begin
            w_fixed = w_mant << (w_exp - 5'd9);
        end else begin
            w_fixed = w_mant >> (5'd9 - w_exp);
        end
    end

    // The top digit never reaches 5 before a shift (max 65504), so only the low
    // four digits need the add-3 correction.
    always_comb begin
        w_adj = 16'd0;
        for (int i = 0; i < 4; i++) begin
            if (bcd_int_q[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = bcd_int_q[i*4 +: 4] + 4'd3;
            end else begin
                w_adj[i*4 +: 4] = bcd_int_q[i*4 +: 4];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        err_cap_d  = err_cap_q;
        int_sr_d   = int_sr_q;
        frac_d     = frac_q;
        bcd_int_d  = bcd_int_q;
        bcd_frac_d = bcd_frac_q;
        cnt_d      = cnt_q;
        sign_out_d = sign_out_q;
        int_bcd_d  = int_bcd_q;
        frac_bcd_d = frac_bcd_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        zero_d     = zero_q;

        case (state_q)
            S_IDLE: begin
                if (ready_in || error_in) begin
                    word_d    = result_in;
                    err_cap_d = error_in;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d      = 4'd0;
                bcd_int_d  = 20'd0;
                bcd_frac_d = 12'd0;
                if (w_special) begin
                    state_d = S_DONE;
                end else begin
                    int_sr_d = w_fixed[31:16];
                    frac_d   = w_fixed[15:0];
                    state_d  = S_INT;
                end
            end
            S_INT: begin
                bcd_int_d = {bcd_int_q[18:16], w_adj, int_sr_q[15]};
                int_sr_d  = {int_sr_q[14:0], 1'b0};
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == C_INT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_FRAC;
                end
            end
            S_FRAC: begin
                frac_d     = w_prod[15:0];
                bcd_frac_d = {bcd_frac_q[7:0], w_prod[19:16]};
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == C_FRAC_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Publish on entry to DONE so the outputs are valid alongside the pulse
        if (state_d == S_DONE && state_q != S_DONE) begin
            sign_out_d = word_q[15];
            int_bcd_d  = bcd_int_d;
            frac_bcd_d = bcd_frac_d;
            ovf_d      = (w_exp == 5'd31);
            err_d      = err_cap_q;
            zero_d     = (w_exp == 5'd0) && (w_frac == 10'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_q     <= 16'd0;
            err_cap_q  <= 1'b0;
            int_sr_q   <= 16'd0;
            frac_q     <= 16'd0;
            bcd_int_q  <= 20'd0;
            bcd_frac_q <= 12'd0;
            cnt_q      <= 4'd0;
            sign_out_q <= 1'b0;
            int_bcd_q  <= 20'd0;
            frac_bcd_q <= 12'd0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            err_cap_q  <= err_cap_d;
            int_sr_q   <= int_sr_d;
            frac_q     <= frac_d;
            bcd_int_q  <= bcd_int_d;
            bcd_frac_q <= bcd_frac_d;
            cnt_q      <= cnt_d;
            sign_out_q <= sign_out_d;
            int_bcd_q  <= int_bcd_d;
            frac_bcd_q <= frac_bcd_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            zero_q     <= zero_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign sign_out = sign_out_q;
    assign int_bcd  = int_bcd_q;
    assign frac_bcd = frac_bcd_q;
    assign ovf      = ovf_q;
    assign err      = err_q;
    assign zero     = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_fp16_result_decoder.sv
// ============================================================================
// tb_fp16_result_decoder : checks fp16_result_decoder against a decimal model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fp16_result_decoder;

    logic        clk;
    logic        rst;
    logic [15:0] result_in;
    logic        ready_in;
    logic        error_in;
    logic        busy;
    logic        done;
    logic        sign_out;
    logic [19:0] int_bcd;
    logic [11:0] frac_bcd;
    logic        ovf;
    logic        err;
    logic        zero;

    int n_checks = 0;
    int n_errors = 0;

    fp16_result_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .result_in(result_in),
        .ready_in (ready_in),
        .error_in (error_in),
        .busy     (busy),
        .done     (done),
        .sign_out (sign_out),
        .int_bcd  (int_bcd),
        .frac_bcd (frac_bcd),
        .ovf      (ovf),
        .err      (err),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {sign, int_bcd, frac_bcd, ovf, err, zero} from decimal arithmetic
    function automatic logic [35:0] model(input logic [15:0] w, input logic e);
        int          exi;
        longint      mant;
        longint      fixed;
        longint      ip;
        longint      fth;
        logic [19:0] ib;
        logic [11:0] fb;
        logic        m_ovf;
        logic        m_zero;
        exi    = int'(w[14:10]);
        m_ovf  = (exi == 31);
        m_zero = (exi == 0) && (w[9:0] == 10'd0);
        ib     = 20'd0;
        fb     = 12'd0;
        if (!e && !m_ovf) begin
            if (exi == 0) begin
                fixed = longint'(w[9:0]) / 256;
            end else begin
                mant  = 1024 + longint'(w[9:0]);
                fixed = (mant * (64'sd1 <<< (exi + 7))) / 65536;
            end
            ip  = fixed / 65536;
            fth = ((fixed % 65536) * 1000) / 65536;
            for (int d = 0; d < 5; d++) begin
                ib[d*4 +: 4] = 4'(ip % 10);
                ip = ip / 10;
            end
            for (int d = 0; d < 3; d++) begin
                fb[d*4 +: 4] = 4'(fth % 10);
                fth = fth / 10;
            end
        end
        return {w[15], ib, fb, m_ovf, e, m_zero};
    endfunction

    task automatic send(input logic [15:0] w, input logic r, input logic e);
        @(negedge clk);
        result_in = w;
        ready_in  = r;
        error_in  = e;
        @(negedge clk);
        ready_in  = 1'b0;
        error_in  = 1'b0;
    endtask

    // Called in cycle N+1; returns k such that done is seen at N+k, or -1
    task automatic wait_done(output int lat);
        int k;
        k = 1;
        while (k <= 40 && done !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        lat = (done === 1'b1) ? k : -1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, sign_out, int_bcd, frac_bcd, ovf, err, zero} !== 38'd0) begin
            n_errors++;
            $display("FAIL reset_state: got busy=%b done=%b sign=%b int=%h frac=%h ovf=%b err=%b zero=%b, expected all 0",
                     busy, done, sign_out, int_bcd, frac_bcd, ovf, err, zero);
        end
    endtask

    task automatic test_directed;
        logic [15:0] words [12] = '{16'h3C00, 16'hC500, 16'h3555, 16'h7BFF, 16'h7C00, 16'h3C00,
                                    16'h0000, 16'h8000, 16'h0001, 16'h4248, 16'h7E00, 16'h03FF};
        logic        rdy   [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
        logic        erri  [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        logic [35:0] exp_v;
        int          exp_lat;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            exp_v   = model(words[i], erri[i]);
            exp_lat = (erri[i] || words[i][14:10] == 5'd31) ? 2 : 21;
            send(words[i], rdy[i], erri[i]);
            wait_done(lat);
            n_checks++;
            if (lat != exp_lat) begin
                n_errors++;
                $display("FAIL directed_latency word=%h: got N+%0d expected N+%0d", words[i], lat, exp_lat);
            end
            n_checks++;
            if ({sign_out, int_bcd, frac_bcd, ovf, err, zero} !== exp_v) begin
                n_errors++;
                $display("FAIL directed_value word=%h: got sign=%b int=%h frac=%h ovf=%b err=%b zero=%b expected sign=%b int=%h frac=%h ovf=%b err=%b zero=%b",
                         words[i], sign_out, int_bcd, frac_bcd, ovf, err, zero,
                         exp_v[35], exp_v[34:15], exp_v[14:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_hold;
        logic [35:0] exp_v;
        int          lat;
        exp_v = model(16'h4248, 1'b0);
        send(16'h4248, 1'b1, 1'b0);
        wait_done(lat);
        repeat (5) begin
            @(negedge clk);
            result_in = 16'($urandom);
        end
        n_checks++;
        if ({done, sign_out, int_bcd, frac_bcd, ovf, err, zero} !== {1'b0, exp_v}) begin
            n_errors++;
            $display("FAIL hold_outputs: got done=%b int=%h frac=%h expected done=0 int=%h frac=%h",
                     done, int_bcd, frac_bcd, exp_v[34:15], exp_v[14:3]);
        end
    endtask

    task automatic test_random;
        logic [15:0] w;
        logic        e;
        logic        r;
        logic [35:0] exp_v;
        int          exp_lat;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            w = 16'($urandom);
            e = ($urandom_range(0, 7) == 0);
            r = e ? 1'($urandom_range(0, 1)) : 1'b1;
            exp_v   = model(w, e);
            exp_lat = (e || w[14:10] == 5'd31) ? 2 : 21;
            send(w, r, e);
            wait_done(lat);
            n_checks++;
            if (lat != exp_lat || {sign_out, int_bcd, frac_bcd, ovf, err, zero} !== exp_v) begin
                n_errors++;
                $display("FAIL random word=%h e=%b: got lat=%0d sign=%b int=%h frac=%h flags=%b%b%b expected lat=%0d sign=%b int=%h frac=%h flags=%b",
                         w, e, lat, sign_out, int_bcd, frac_bcd, ovf, err, zero,
                         exp_lat, exp_v[35], exp_v[34:15], exp_v[14:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic test_busy_drop;
        int first_done;
        int n_done;
        send(16'h3C00, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_mid_conv: got busy=%b expected 1", busy);
        end
        result_in = 16'h4500;
        ready_in  = 1'b1;
        @(negedge clk);
        ready_in  = 1'b0;
        first_done = -1;
        n_done     = 0;
        for (int k = 6; k <= 60; k++) begin
            if (done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            @(negedge clk);
        end
        n_checks++;
        if (first_done != 21 || n_done != 1) begin
            n_errors++;
            $display("FAIL busy_drop: got first done N+%0d count %0d expected N+21 count 1", first_done, n_done);
        end
        n_checks++;
        if (int_bcd !== 20'h00001 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_drop_value: got int=%h busy=%b expected int=00001 busy=0", int_bcd, busy);
        end
    endtask

    task automatic test_reset_mid;
        int n_done;
        send(16'h7BFF, 1'b1, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, sign_out, int_bcd, frac_bcd, ovf, err, zero} !== 38'd0) begin
            n_errors++;
            $display("FAIL reset_mid_state: got busy=%b done=%b sign=%b int=%h frac=%h ovf=%b err=%b zero=%b, expected all 0",
                     busy, done, sign_out, int_bcd, frac_bcd, ovf, err, zero);
        end
        n_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_errors++;
            $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", n_done);
        end
    endtask

    task automatic test_after_reset;
        logic [35:0] exp_v;
        int          lat;
        exp_v = model(16'hC500, 1'b0);
        send(16'hC500, 1'b1, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat != 21 || {sign_out, int_bcd, frac_bcd, ovf, err, zero} !== exp_v) begin
            n_errors++;
            $display("FAIL after_reset: got lat=%0d sign=%b int=%h frac=%h expected lat=21 sign=%b int=%h frac=%h",
                     lat, sign_out, int_bcd, frac_bcd, exp_v[35], exp_v[34:15], exp_v[14:3]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        result_in = 16'd0;
        ready_in  = 1'b0;
        error_in  = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_busy_drop();
        test_reset_mid();
        test_after_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
